// File: rtl/core_pkg.sv
// Core-wide widths shared by the result path, plus the common-data-bus packet type
// and a small modular-increment helper used by the round-robin arbiter.
package core_pkg;

    localparam int unsigned CPU_NUM_LANES = 4;
    localparam int unsigned ROB_SIZE_CLOG = 5;
    localparam int unsigned DATA_LEN      = 32;
    localparam int unsigned CPU_LANE_W    = $clog2(CPU_NUM_LANES);

    typedef struct packed {
        logic                     v;
        logic [ROB_SIZE_CLOG-1:0] robid;
        logic [DATA_LEN-1:0]      data;
        logic [CPU_LANE_W-1:0]    lane;
    } cdb_pkt_t;

    // Legacy name for the broadcast input bundle.
    typedef cdb_pkt_t cdb_in_t;

    // (base + off) mod n, valid for base < n and off <= n.
    function automatic int unsigned rr_wrap(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/cdb_lane_fifo.sv
// Per-lane result queue: circular buffer with occupancy count and a flush that
// empties it in one cycle. The caller never pushes into a full queue.
module cdb_lane_fifo import core_pkg::*; #(
    parameter int unsigned Q_DEPTH = 4,
    parameter int unsigned WIDTH   = ROB_SIZE_CLOG + DATA_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(Q_DEPTH):0] count
);

    localparam int unsigned PW = $clog2(Q_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [Q_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: slots are only read once counted as occupied.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Multi-port common-data-bus arbiter: per-lane result queues, round-robin grant of up
// to NUM_CDB lanes per cycle, registered broadcast ports, flush and sticky overflow flag.
module cdb_arbiter #(
    parameter int unsigned NUM_LANES     = core_pkg::CPU_NUM_LANES,
    parameter int unsigned NUM_CDB       = 2,
    parameter int unsigned Q_DEPTH       = 4,
    parameter int unsigned ROB_SIZE_CLOG = core_pkg::ROB_SIZE_CLOG,
    parameter int unsigned DATA_LEN      = core_pkg::DATA_LEN
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_LANES-1:0]                        lane_v_i,
    input  logic [NUM_LANES-1:0][ROB_SIZE_CLOG-1:0]     lane_robid_i,
    input  logic [NUM_LANES-1:0][DATA_LEN-1:0]          lane_data_i,
    output logic [NUM_LANES-1:0]                        lane_rdy_o,
    input  logic                                        flush_i,
    output logic [NUM_CDB-1:0]                          cdb_v_o,
    output logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0]       cdb_robid_o,
    output logic [NUM_CDB-1:0][DATA_LEN-1:0]            cdb_data_o,
    output logic [NUM_CDB-1:0][$clog2(NUM_LANES)-1:0]   cdb_lane_o,
    output logic                                        overflow_err_o
);

    localparam int unsigned LW = $clog2(NUM_LANES);
    localparam int unsigned CW = $clog2(Q_DEPTH) + 1;
    localparam int unsigned EW = ROB_SIZE_CLOG + DATA_LEN;

    logic [NUM_LANES-1:0][CW-1:0] count;
    logic [NUM_LANES-1:0][EW-1:0] head;
    logic [NUM_LANES-1:0]         full;
    logic [NUM_LANES-1:0]         nonempty;
    logic [NUM_LANES-1:0]         push;
    logic [NUM_LANES-1:0]         grant;

    logic [NUM_CDB-1:0]           port_v;
    logic [NUM_CDB-1:0][LW-1:0]   port_lane;
    logic [LW-1:0]                last_lane;
    int unsigned                  n_grant;

    logic [LW-1:0]                         rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0]                    cdb_v_q, cdb_v_d;
    logic [NUM_CDB-1:0][ROB_SIZE_CLOG-1:0] cdb_robid_q, cdb_robid_d;
    logic [NUM_CDB-1:0][DATA_LEN-1:0]      cdb_data_q, cdb_data_d;
    logic [NUM_CDB-1:0][LW-1:0]            cdb_lane_q, cdb_lane_d;
    logic                                  ovf_q, ovf_d;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign full[i]       = (count[i] == CW'(Q_DEPTH));
        assign nonempty[i]   = (count[i] != '0);
        assign lane_rdy_o[i] = rst & ~full[i];
        assign push[i]       = lane_v_i[i] & lane_rdy_o[i];

        cdb_lane_fifo #(
            .Q_DEPTH (Q_DEPTH),
            .WIDTH   (EW)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[i]),
            .pop   (grant[i]),
            .flush (flush_i),
            .din   ({lane_robid_i[i], lane_data_i[i]}),
            .dout  (head[i]),
            .count (count[i])
        );
    end

    // Scan from rr_ptr; the k-th non-empty lane found goes to port k.
    always_comb begin
        logic [LW-1:0] lane_idx;
        grant     = '0;
        port_v    = '0;
        port_lane = '0;
        last_lane = rr_ptr_q;
        n_grant   = 0;
        lane_idx  = '0;
        for (int unsigned j = 0; j < NUM_LANES; j++) begin
            lane_idx = LW'(core_pkg::rr_wrap(32'(rr_ptr_q), j, NUM_LANES));
            if (nonempty[lane_idx] && (n_grant < NUM_CDB)) begin
                grant[lane_idx] = 1'b1;
                for (int unsigned k = 0; k < NUM_CDB; k++) begin
                    if (k == n_grant) begin
                        port_v[k]    = 1'b1;
                        port_lane[k] = lane_idx;
                    end
                end
                last_lane = lane_idx;
                n_grant   = n_grant + 1;
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_v_d     = '0;
        cdb_robid_d = cdb_robid_q;
        cdb_data_d  = cdb_data_q;
        cdb_lane_d  = cdb_lane_q;
        ovf_d       = ovf_q;
        if (flush_i) begin
            rr_ptr_d = '0;
        end else begin
            ovf_d   = ovf_q | (|(lane_v_i & full));
            cdb_v_d = port_v;
            if (n_grant != 0) begin
                rr_ptr_d = LW'(core_pkg::rr_wrap(32'(last_lane), 1, NUM_LANES));
            end
            // Idle ports keep their last payload; only valid drops.
            for (int unsigned k = 0; k < NUM_CDB; k++) begin
                if (port_v[k]) begin
                    cdb_robid_d[k] = head[port_lane[k]][EW-1:DATA_LEN];
                    cdb_data_d[k]  = head[port_lane[k]][DATA_LEN-1:0];
                    cdb_lane_d[k]  = port_lane[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            cdb_v_q     <= '0;
            cdb_robid_q <= '0;
            cdb_data_q  <= '0;
            cdb_lane_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_v_q     <= cdb_v_d;
            cdb_robid_q <= cdb_robid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_lane_q  <= cdb_lane_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cdb_v_o        = cdb_v_q;
    assign cdb_robid_o    = cdb_robid_q;
    assign cdb_data_o     = cdb_data_q;
    assign cdb_lane_o     = cdb_lane_q;
    assign overflow_err_o = ovf_q;

endmodule
